// File: rtl/flip_alpha_gen_pkg.sv
// Shared constants, state encoding and field helpers for the flip-term generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flip_alpha_gen_pkg;

  localparam logic [1:0] CODE_63   = 2'b00;
  localparam logic [1:0] CODE_255  = 2'b01;
  localparam logic [1:0] CODE_1023 = 2'b10;

  localparam logic [3:0] M_63   = 4'd6;
  localparam logic [3:0] M_255  = 4'd8;
  localparam logic [3:0] M_1023 = 4'd10;

  localparam logic [9:0] ALPHA = 10'h002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXP,
    ST_SQ,
    ST_P3,
    ST_P5,
    ST_P7,
    ST_DONE
  } state_t;

  // The reserved code selects the largest field.
  function automatic logic [1:0] norm_code(input logic [1:0] c);
    return (c == 2'b11) ? CODE_1023 : c;
  endfunction

  function automatic logic [3:0] field_m(input logic [1:0] c);
    case (c)
      CODE_63:  return M_63;
      CODE_255: return M_255;
      default:  return M_1023;
    endcase
  endfunction

  // Primitive polynomials, including the x^m term.
  function automatic logic [10:0] field_poly(input logic [1:0] c);
    case (c)
      CODE_63:  return 11'h043;  // x^6 + x + 1
      CODE_255: return 11'h11D;  // x^8 + x^4 + x^3 + x^2 + 1
      default:  return 11'h409;  // x^10 + x^3 + 1
    endcase
  endfunction

endpackage

// File: rtl/flip_alpha_gen_if.sv
// Request/result bundle between the flip-term producer and its requester.
// Latency: n/a (wiring only).
// Backpressure: none; results are held with valid until cleared or restarted.
interface flip_alpha_gen_if #(
  parameter int POS_W = 10,
  parameter int SYM_W = 10
);
  logic [1:0]       i_code;
  logic             i_start;
  logic             i_clear;
  logic [POS_W-1:0] i_pos1;
  logic [POS_W-1:0] i_pos2;
  logic [SYM_W-1:0] o_flip_alpha_S1_1;
  logic [SYM_W-1:0] o_flip_alpha_S3_1;
  logic [SYM_W-1:0] o_flip_alpha_S5_1;
  logic [SYM_W-1:0] o_flip_alpha_S7_1;
  logic [SYM_W-1:0] o_flip_alpha_S1_2;
  logic [SYM_W-1:0] o_flip_alpha_S3_2;
  logic [SYM_W-1:0] o_flip_alpha_S5_2;
  logic [SYM_W-1:0] o_flip_alpha_S7_2;
  logic             o_flip_alpha_valid;
  logic             o_busy;

  modport master (
    output i_code, i_start, i_clear, i_pos1, i_pos2,
    input  o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1,
    input  o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2,
    input  o_flip_alpha_valid, o_busy
  );

  modport slave (
    input  i_code, i_start, i_clear, i_pos1, i_pos2,
    output o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1,
    output o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2,
    output o_flip_alpha_valid, o_busy
  );
endinterface

// File: rtl/flip_alpha_lane.sv
// One position lane: alpha^p by MSB-first square-and-multiply, then odd powers via r*alpha^2p.
// Latency: follows the shared FSM (result registers written in P3/P5/P7).
// Backpressure: none; registers hold until clear or overwrite.
module flip_alpha_lane import flip_alpha_gen_pkg::*; #(
  parameter int SYM_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_code,
  input  state_t           i_state,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_bit,
  output logic [SYM_W-1:0] o_s1,
  output logic [SYM_W-1:0] o_s3,
  output logic [SYM_W-1:0] o_s5,
  output logic [SYM_W-1:0] o_s7
);

  logic [SYM_W-1:0] r_r;
  logic [SYM_W-1:0] r_q;
  logic [SYM_W-1:0] r_s1, r_s3, r_s5, r_s7;
  logic [SYM_W-1:0] w_sq;
  logic [SYM_W-1:0] w_sqa;
  logic [SYM_W-1:0] w_prod;
  logic [SYM_W-1:0] w_alpha;

  assign w_alpha = SYM_W'(ALPHA);

  gf_mult #(.SYM_W(SYM_W)) u_sq    (.i_a(r_r),  .i_b(r_r),     .i_code(i_code), .o_product(w_sq));
  gf_mult #(.SYM_W(SYM_W)) u_alpha (.i_a(w_sq), .i_b(w_alpha), .i_code(i_code), .o_product(w_sqa));
  gf_mult #(.SYM_W(SYM_W)) u_gen   (.i_a(r_r),  .i_b(r_q),     .i_code(i_code), .o_product(w_prod));

  // Working/square registers and result capture; S7 takes the P7 product directly so all
  // four results are in place the first cycle valid is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_r  <= '0;
      r_q  <= '0;
      r_s1 <= '0;
      r_s3 <= '0;
      r_s5 <= '0;
      r_s7 <= '0;
    end else if (i_clear) begin
      r_r  <= '0;
      r_q  <= '0;
      r_s1 <= '0;
      r_s3 <= '0;
      r_s5 <= '0;
      r_s7 <= '0;
    end else if (i_load) begin
      r_r <= SYM_W'(1);
    end else begin
      case (i_state)
        ST_EXP: r_r <= i_bit ? w_sqa : w_sq;
        ST_SQ:  r_q <= w_sq;
        ST_P3: begin
          r_s1 <= r_r;
          r_r  <= w_prod;
        end
        ST_P5: begin
          r_s3 <= r_r;
          r_r  <= w_prod;
        end
        ST_P7: begin
          r_s5 <= r_r;
          r_s7 <= w_prod;
          r_r  <= w_prod;
        end
        default: ;
      endcase
    end
  end

  assign o_s1 = r_s1;
  assign o_s3 = r_s3;
  assign o_s5 = r_s5;
  assign o_s7 = r_s7;

endmodule

// File: rtl/gf_mult.sv
// GF(2^m) multiplier, m chosen by code; operands assumed below 2^m, result always is.
// Latency: combinational.
// Backpressure: none.
module gf_mult import flip_alpha_gen_pkg::*; #(
  parameter int SYM_W = 10
) (
  input  logic [SYM_W-1:0] i_a,
  input  logic [SYM_W-1:0] i_b,
  input  logic [1:0]       i_code,
  output logic [SYM_W-1:0] o_product
);

  logic [3:0]       w_m;
  logic [SYM_W-1:0] w_mask;
  logic [SYM_W:0]   w_sh;
  logic [SYM_W-1:0] w_acc;

  // Shift-and-add with reduction after every shift so the partial stays inside the field.
  always_comb begin
    w_m   = field_m(i_code);
    w_mask = '0;
    for (int i = 0; i < SYM_W; i++) begin
      w_mask[i] = (i < int'(w_m));
    end
    w_sh  = {1'b0, i_a & w_mask};
    w_acc = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if ((i < int'(w_m)) && i_b[i]) begin
        w_acc = w_acc ^ w_sh[SYM_W-1:0];
      end
      w_sh = w_sh << 1;
      if (w_sh[w_m]) begin
        w_sh = w_sh ^ (SYM_W+1)'(field_poly(i_code));
      end
    end
    o_product = w_acc;
  end

endmodule

// File: rtl/flip_alpha_gen.sv
// Chase flip-term producer: alpha^(k*p) for k=1,3,5,7 on two positions, one shared FSM.
// Latency: start accepted at T, valid from T+15 (POS_W=10).
// Backpressure: start ignored while busy; results and valid held until clear or new start.
module flip_alpha_gen import flip_alpha_gen_pkg::*; #(
  parameter int POS_W = 10,
  parameter int SYM_W = 10
) (
  input logic            i_clk,
  input logic            i_rst_n,
  flip_alpha_gen_if.slave io_bus
);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [1:0]       r_code;
  logic [POS_W-1:0] r_pos1;
  logic [POS_W-1:0] r_pos2;
  logic [POS_W-1:0] r_cnt;
  logic             r_valid;
  logic [POS_W-1:0] w_sh1;
  logic [POS_W-1:0] w_sh2;
  logic             w_wide;
  logic [SYM_W-1:0] w_s1_1, w_s3_1, w_s5_1, w_s7_1;
  logic [SYM_W-1:0] w_s1_2, w_s3_2, w_s5_2, w_s7_2;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state and accept strobe; clear overrides any start.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    if (io_bus.i_clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (io_bus.i_start) begin
            w_next   = ST_EXP;
            w_accept = 1'b1;
          end
        end
        ST_EXP:  if (r_cnt == '0) w_next = ST_SQ;
        ST_SQ:   w_next = ST_P3;
        ST_P3:   w_next = ST_P5;
        ST_P5:   w_next = ST_P7;
        ST_P7:   w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Request latches, exponent bit counter and valid (high exactly while in DONE).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code  <= CODE_63;
      r_pos1  <= '0;
      r_pos2  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_next == ST_DONE);
      if (w_accept) begin
        r_code <= norm_code(io_bus.i_code);
        r_pos1 <= io_bus.i_pos1;
        r_pos2 <= io_bus.i_pos2;
        r_cnt  <= POS_W'(POS_W - 1);
      end else if (r_state == ST_EXP && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign w_sh1 = r_pos1 >> r_cnt;
  assign w_sh2 = r_pos2 >> r_cnt;

  flip_alpha_lane #(.SYM_W(SYM_W)) u_lane1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(r_code), .i_state(r_state),
    .i_load(w_accept), .i_clear(io_bus.i_clear), .i_bit(w_sh1[0]),
    .o_s1(w_s1_1), .o_s3(w_s3_1), .o_s5(w_s5_1), .o_s7(w_s7_1)
  );

  flip_alpha_lane #(.SYM_W(SYM_W)) u_lane2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(r_code), .i_state(r_state),
    .i_load(w_accept), .i_clear(io_bus.i_clear), .i_bit(w_sh2[0]),
    .o_s1(w_s1_2), .o_s3(w_s3_2), .o_s5(w_s5_2), .o_s7(w_s7_2)
  );

  // S5/S7 only exist for the 1023 field; smaller codes report zero there.
  assign w_wide = (r_code == CODE_1023);

  assign io_bus.o_flip_alpha_S1_1  = w_s1_1;
  assign io_bus.o_flip_alpha_S3_1  = w_s3_1;
  assign io_bus.o_flip_alpha_S5_1  = w_wide ? w_s5_1 : '0;
  assign io_bus.o_flip_alpha_S7_1  = w_wide ? w_s7_1 : '0;
  assign io_bus.o_flip_alpha_S1_2  = w_s1_2;
  assign io_bus.o_flip_alpha_S3_2  = w_s3_2;
  assign io_bus.o_flip_alpha_S5_2  = w_wide ? w_s5_2 : '0;
  assign io_bus.o_flip_alpha_S7_2  = w_wide ? w_s7_2 : '0;
  assign io_bus.o_flip_alpha_valid = r_valid;
  assign io_bus.o_busy = (r_state == ST_EXP) || (r_state == ST_SQ) || (r_state == ST_P3) ||
                         (r_state == ST_P5)  || (r_state == ST_P7);

endmodule

// File: tb/tb_flip_alpha_gen.sv
// Self-checking bench for flip_alpha_gen: directed, random and control scenarios.
// Latency: expects valid at T+15 after the accept cycle T.
// Backpressure: exercises start-while-busy, restart in DONE, clear and async reset.
module tb_flip_alpha_gen;

  typedef logic [7:0][9:0] res_t;  // [0..3]=S1,S3,S5,S7 lane 1; [4..7] lane 2

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  flip_alpha_gen_if #(.POS_W(10), .SYM_W(10)) u_if ();

  flip_alpha_gen #(.POS_W(10), .SYM_W(10)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(u_if.slave)
  );

  // ---------------- reference model: full product, then long-division reduction
  function automatic int m_width(input logic [1:0] c);
    return (c == 2'b00) ? 6 : (c == 2'b01) ? 8 : 10;
  endfunction

  function automatic logic [10:0] m_poly(input logic [1:0] c);
    return (c == 2'b00) ? 11'h043 : (c == 2'b01) ? 11'h11D : 11'h409;
  endfunction

  function automatic logic [9:0] m_mul(input logic [9:0] a, input logic [9:0] b, input logic [1:0] c);
    logic [19:0] p;
    int m;
    m = m_width(c);
    p = '0;
    for (int i = 0; i < 10; i++) if (b[i]) p = p ^ (20'(a) << i);
    for (int i = 19; i >= m; i--) if (p[i]) p = p ^ (20'(m_poly(c)) << (i - m));
    return p[9:0];
  endfunction

  function automatic logic [9:0] m_pow(input logic [9:0] p, input logic [1:0] c);
    logic [9:0] x;
    int e;
    e = int'(p) % ((1 << m_width(c)) - 1);
    x = 10'h001;
    for (int i = 0; i < e; i++) x = m_mul(x, 10'h002, c);
    return x;
  endfunction

  function automatic res_t expect_res(input logic [1:0] code, input logic [9:0] p1, input logic [9:0] p2);
    res_t r;
    logic [1:0] c;
    logic [9:0] s1, s3, s5, s7;
    c = (code == 2'b11) ? 2'b10 : code;
    for (int l = 0; l < 2; l++) begin
      s1 = m_pow((l == 0) ? p1 : p2, c);
      s3 = m_mul(m_mul(s1, s1, c), s1, c);
      s5 = m_mul(m_mul(s3, s1, c), s1, c);
      s7 = m_mul(m_mul(s5, s1, c), s1, c);
      if (c != 2'b10) begin
        s5 = '0;
        s7 = '0;
      end
      r[4*l+0] = s1;
      r[4*l+1] = s3;
      r[4*l+2] = s5;
      r[4*l+3] = s7;
    end
    return r;
  endfunction

  function automatic res_t read_outs();
    res_t r;
    r[0] = u_if.o_flip_alpha_S1_1;
    r[1] = u_if.o_flip_alpha_S3_1;
    r[2] = u_if.o_flip_alpha_S5_1;
    r[3] = u_if.o_flip_alpha_S7_1;
    r[4] = u_if.o_flip_alpha_S1_2;
    r[5] = u_if.o_flip_alpha_S3_2;
    r[6] = u_if.o_flip_alpha_S5_2;
    r[7] = u_if.o_flip_alpha_S7_2;
    return r;
  endfunction

  // One full operation: push expectation, start, optionally poke start mid-run,
  // then pop and compare when valid appears.
  task automatic do_op(input logic [1:0] code, input logic [9:0] p1, input logic [9:0] p2,
                       input res_t exp_in, input int glitch_cyc, input string name);
    res_t exp_r, act;
    int cyc;
    sb_q.push_back(exp_in);
    @(negedge clk);
    u_if.i_code  = code;
    u_if.i_pos1  = p1;
    u_if.i_pos2  = p2;
    u_if.i_start = 1'b1;
    @(negedge clk);
    u_if.i_start = 1'b0;
    cyc = 1;
    n_tests++;
    if (u_if.o_busy !== 1'b1 || u_if.o_flip_alpha_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b valid=%b, required busy=1 valid=0", name, u_if.o_busy, u_if.o_flip_alpha_valid);
    end
    while (u_if.o_flip_alpha_valid !== 1'b1 && cyc < 40) begin
      if (cyc == glitch_cyc) begin
        u_if.i_start = 1'b1;
        u_if.i_pos1  = ~p1;
        u_if.i_pos2  = ~p2;
        u_if.i_code  = code ^ 2'b01;
      end
      @(negedge clk);
      u_if.i_start = 1'b0;
      cyc++;
    end
    n_tests++;
    if (cyc !== 15) begin
      n_fail++;
      $display("FAIL %s latency: valid at T+%0d, required T+15", name, cyc);
    end
    exp_r = sb_q.pop_front();
    act = read_outs();
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (act[i] !== exp_r[i]) begin
        n_fail++;
        $display("FAIL %s out[%0d]: got %h, required %h", name, i, act[i], exp_r[i]);
      end
    end
    @(negedge clk);
    n_tests++;
    if (u_if.o_flip_alpha_valid !== 1'b1 || read_outs() !== exp_r) begin
      n_fail++;
      $display("FAIL %s hold: valid=%b outs=%h, required valid=1 outs=%h", name, u_if.o_flip_alpha_valid, read_outs(), exp_r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.i_code = 2'b00; u_if.i_start = 1'b0; u_if.i_clear = 1'b0;
    u_if.i_pos1 = '0;    u_if.i_pos2 = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (read_outs() !== '0 || u_if.o_flip_alpha_valid !== 1'b0 || u_if.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: outs=%h valid=%b busy=%b, required all 0", read_outs(), u_if.o_flip_alpha_valid, u_if.o_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    res_t e;
    e = '0;
    e[0] = 10'h001; e[1] = 10'h001; e[2] = 10'h001; e[3] = 10'h001;
    e[4] = 10'h002; e[5] = 10'h008; e[6] = 10'h020; e[7] = 10'h080;
    do_op(2'b10, 10'd0, 10'd1, e, 0, "dir_c10");
    e = '0;
    e[0] = 10'h002; e[1] = 10'h008; e[4] = 10'h001; e[5] = 10'h001;
    do_op(2'b00, 10'd1, 10'd0, e, 0, "dir_c00");
    e = '0;
    e[0] = 10'h004; e[1] = 10'h040; e[4] = 10'h002; e[5] = 10'h008;
    do_op(2'b01, 10'd2, 10'd1, e, 0, "dir_c01");
  endtask

  task automatic test_random();
    logic [9:0] p1, p2;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) begin
        p1 = 10'($urandom_range(0, 1023));
        p2 = 10'($urandom_range(0, 1023));
        do_op(2'(c), p1, p2, expect_res(2'(c), p1, p2), 0, "random");
      end
    end
  endtask

  task automatic test_field_wrap();
    logic [9:0] p;
    for (int c = 0; c < 3; c++) begin
      p = 10'((1 << m_width(2'(c))) - 1);
      do_op(2'(c), p, p, expect_res(2'(c), p, p), 0, "wrap");
    end
  endtask

  task automatic test_back_to_back();
    do_op(2'b10, 10'd123, 10'd777, expect_res(2'b10, 10'd123, 10'd777), 5, "busy_start");
    do_op(2'b10, 10'd600, 10'd45, expect_res(2'b10, 10'd600, 10'd45), 0, "restart_done");
  endtask

  task automatic test_clear();
    @(negedge clk);
    u_if.i_code = 2'b10; u_if.i_pos1 = 10'd3; u_if.i_pos2 = 10'd7; u_if.i_start = 1'b1;
    @(negedge clk);
    u_if.i_start = 1'b0;
    repeat (7) @(negedge clk);
    u_if.i_clear = 1'b1;
    @(negedge clk);
    u_if.i_clear = 1'b0;
    n_tests++;
    if (u_if.o_busy !== 1'b0 || u_if.o_flip_alpha_valid !== 1'b0 || read_outs() !== '0) begin
      n_fail++;
      $display("FAIL clear: busy=%b valid=%b outs=%h, required all 0", u_if.o_busy, u_if.o_flip_alpha_valid, read_outs());
    end
    u_if.i_clear = 1'b1;
    u_if.i_start = 1'b1;
    @(negedge clk);
    u_if.i_clear = 1'b0;
    u_if.i_start = 1'b0;
    n_tests++;
    if (u_if.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_vs_start: busy=%b, required 0", u_if.o_busy);
    end
  endtask

  task automatic test_async_reset();
    do_op(2'b10, 10'd5, 10'd9, expect_res(2'b10, 10'd5, 10'd9), 0, "pre_reset");
    @(negedge clk);
    u_if.i_pos1 = 10'd11; u_if.i_pos2 = 10'd22; u_if.i_start = 1'b1;
    @(negedge clk);
    u_if.i_start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (read_outs() !== '0 || u_if.o_flip_alpha_valid !== 1'b0 || u_if.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: outs=%h valid=%b busy=%b, required all 0", read_outs(), u_if.o_flip_alpha_valid, u_if.o_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b01, 10'd200, 10'd17, expect_res(2'b01, 10'd200, 10'd17), 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_field_wrap();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
